// File: rtl/nrz_pkg.sv
// nrz_pkg: shared types and helpers for the nrz_stream serialiser.
//   nrz_state_e : serialiser FSM states (IDLE, BIT, LATCH)
//   high_ticks  : high-phase length, in clken ticks, for one data bit
//   grb_reorder : {R,G,B} -> {G,R,B} for 24-bit pixels
package nrz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    LATCH
  } nrz_state_e;

  function automatic int high_ticks(input logic b, input int t0h, input int t1h);
    return b ? t1h : t0h;
  endfunction

  function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/nrz_hold.sv
// nrz_hold: one-entry pixel holding register in front of the serialiser.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   load                  accepted transfer this clk (s_valid & ready)
//   load_data, load_last  incoming pixel and its end-of-frame flag
//   drain                 serialiser takes the held pixel this clk
//   data, last            held pixel and flag (valid while full)
//   full                  entry occupied
//   ready                 registered !full, drives the stream s_ready
module nrz_hold
  import nrz_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  drain,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  full,
  output logic                  ready
);

  // ready is kept as its own flop (always !full) so s_ready never depends
  // combinationally on s_valid or on the serialiser.
  // A load wins over a drain: the entry then holds the new pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      full  <= 1'b0;
      ready <= 1'b1;
    end else if (load) begin
      full  <= 1'b1;
      ready <= 1'b0;
    end else if (drain) begin
      full  <= 1'b0;
      ready <= 1'b1;
    end
  end

  // NOTE: the payload is not reset; it is only ever read while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
      last <= load_last;
    end
  end

endmodule

// File: rtl/nrz_stream.sv
// nrz_stream: multi-pixel WS2818-style NRZ serialiser.
// Pixels arrive over a valid/ready stream, are shifted out MSB-first with
// no gap between pixels, and each frame ends with a low latch gap.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   clken        one-clk timing tick; all FSM/counter/dout updates use it
//   s_valid, s_data, s_last, s_ready   pixel stream input
//   dout         registered serial output to the LED data pin
//   busy         FSM not IDLE or a pixel is held
//   done         one-clk pulse at the end of the latch gap
//   underrun     sticky: pixel boundary hit with no pixel and no s_last
// Build option: define NRZ_GRB_ORDER_EN to reorder {R,G,B} input pixels
// to {G,R,B} on the wire (DATA_WIDTH must then be 24).
module nrz_stream
  import nrz_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int BIT_TICKS   = 4,
  parameter int T0H_TICKS   = 1,
  parameter int T1H_TICKS   = 2,
  parameter int LATCH_TICKS = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  dout,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int LAT_W  = $clog2(LATCH_TICKS + 1);

  typedef logic [TICK_W-1:0] tick_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [LAT_W-1:0]  lat_t;

  if (!(T0H_TICKS < T1H_TICKS && T1H_TICKS < BIT_TICKS && LATCH_TICKS >= 1)) begin : g_bad_timing
    $error("nrz_stream: need T0H_TICKS < T1H_TICKS < BIT_TICKS and LATCH_TICKS >= 1");
  end

`ifdef NRZ_GRB_ORDER_EN
  if (DATA_WIDTH != 24) begin : g_bad_grb_width
    $error("nrz_stream: NRZ_GRB_ORDER_EN requires DATA_WIDTH == 24");
  end
`endif

  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;
  logic                  hold_full;
  logic                  drain;
  logic [DATA_WIDTH-1:0] load_data;

  nrz_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (s_valid && s_ready),
    .load_data(s_data),
    .load_last(s_last),
    .drain    (drain),
    .data     (hold_data),
    .last     (hold_last),
    .full     (hold_full),
    .ready    (s_ready)
  );

`ifdef NRZ_GRB_ORDER_EN
  assign load_data = grb_reorder(hold_data);
`else
  assign load_data = hold_data;
`endif

  nrz_state_e            state_q, state_d;
  tick_t                 tick_q, tick_d;
  cnt_t                  bit_q, bit_d;
  lat_t                  lat_q, lat_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  last_q, last_d;
  logic                  dout_d, done_d, underrun_d;

  assign busy = (state_q != IDLE) || hold_full;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    lat_d      = lat_q;
    shift_d    = shift_q;
    last_d     = last_q;
    dout_d     = dout;
    done_d     = 1'b0;
    underrun_d = underrun;
    drain      = 1'b0;

    if (clken) begin
      unique case (state_q)
        IDLE: begin
          dout_d = 1'b0;
          if (hold_full) begin
            shift_d = load_data;
            last_d  = hold_last;
            bit_d   = '0;
            tick_d  = '0;
            drain   = 1'b1;
            dout_d  = 1'b1;
            state_d = BIT;
          end
        end

        BIT: begin
          dout_d = tick_q < tick_t'(high_ticks(shift_q[DATA_WIDTH-1], T0H_TICKS, T1H_TICKS));
          if (tick_q == tick_t'(BIT_TICKS - 1)) begin
            tick_d  = '0;
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == cnt_t'(DATA_WIDTH - 1)) begin
              bit_d = '0;
              if (last_q) begin
                lat_d   = '0;
                state_d = LATCH;
              end else if (hold_full) begin
                // Seamless hand-over: next pixel's first bit starts next tick.
                shift_d = load_data;
                last_d  = hold_last;
                drain   = 1'b1;
              end else begin
                underrun_d = 1'b1;
                lat_d      = '0;
                state_d    = LATCH;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        LATCH: begin
          dout_d = 1'b0;
          if (lat_q == lat_t'(LATCH_TICKS - 1)) begin
            lat_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      lat_q    <= '0;
      last_q   <= 1'b0;
      dout     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      lat_q    <= lat_d;
      last_q   <= last_d;
      dout     <= dout_d;
      done     <= done_d;
      underrun <= underrun_d;
    end
  end

  // Shift contents are meaningless outside BIT, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_nrz_stream.sv
// tb_nrz_stream: table-driven bench for nrz_stream with clken every 4 clk.
// Each clken edge's dout is recorded from the first rising edge on; the
// record is compared with a per-tick waveform built from the pixel values
// (load tick high, then 4 ticks per bit: 2 high for 1, 1 high for 0, then
// 200 latch ticks low with done on the last one).
module tb_nrz_stream;

  logic        clk = 1'b0;
  logic        reset, clken, s_valid, s_last;
  logic [23:0] s_data;
  logic        s_ready, dout, busy, done, underrun;

  nrz_stream dut (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             n;
    logic [2:0][23:0] data;
    logic [2:0]     last;
    logic [2:0][7:0] delay;     // clken ticks after previous transfer
    logic [2:0]     brk;        // frame (latch gap) ends after this pixel
    logic [2:0][23:0] exp;      // expected wire order of each pixel
    int             exp_done;
    logic           exp_underrun;
    logic           exp_stall;
  } scen_t;

  scen_t tbl [4];

  int vec_cnt = 0;
  int miss_cnt = 0;

  // source / monitor state
  scen_t  cur;
  int     src_idx, since, div, cyc;
  logic   rdy_q, capturing;
  logic   rec [$];
  int     done_idx [$];
  int     done_cnt, stall_seen, hi_clks, xfer_cyc, rise_cyc;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] nrz_pattern(input logic [23:0] v);
    logic [95:0] r = '0;
    for (int b = 23; b >= 0; b--)
      for (int t = 0; t < 4; t++)
        r = (r << 1) | 96'(t < (v[b] ? 2 : 1));
    return r;
  endfunction

  // One clk: observe the edge, then update monitor and source at negedge.
  task automatic step();
    logic edge_ck, xfer;
    @(posedge clk);
    edge_ck = clken;
    xfer    = s_valid && rdy_q;
    @(negedge clk);
    cyc++;
    if (dout) hi_clks++;
    if (edge_ck) begin
      if (!capturing && dout) begin
        capturing = 1'b1;
        rise_cyc  = cyc;
      end
      if (capturing) rec.push_back(dout);
      since++;
    end
    if (done) begin
      done_cnt++;
      done_idx.push_back(rec.size() - 1);
    end
    if (xfer) begin
      if (src_idx == 0) xfer_cyc = cyc;
      src_idx++;
      since   = 0;
      s_valid = 1'b0;
    end
    if (!s_valid && src_idx < cur.n && since >= int'(cur.delay[src_idx])) begin
      s_valid = 1'b1;
      s_data  = cur.data[src_idx];
      s_last  = cur.last[src_idx];
    end
    if (s_valid && !s_ready) stall_seen++;
    rdy_q = s_ready;
    clken = (div == 3);
    div   = (div + 1) % 4;
  endtask

  task automatic clear_monitor();
    src_idx = 0; since = 0; capturing = 1'b0;
    rec.delete(); done_idx.delete();
    done_cnt = 0; stall_seen = 0; hi_clks = 0; xfer_cyc = 0; rise_cyc = 0;
  endtask

  task automatic run_scenario(input int k, input logic do_reset);
    int guard, pos, j, ones;
    logic [95:0] act;
    cur.n = 0;
    if (do_reset) begin
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check($sformatf("s%0d reset {dout,done,underrun,busy,s_ready}", k),
            96'({dout, done, underrun, busy, s_ready}), 96'(5'b00001));
    end
    clear_monitor();
    cur = tbl[k];
    guard = 0;
    while (!(src_idx == cur.n && done_cnt >= cur.exp_done) && guard < 8000) begin
      step();
      guard++;
    end
    check($sformatf("s%0d timeout", k), 96'(guard >= 8000), 96'(0));
    repeat (80) step();

    pos = 0;
    j   = 0;
    for (int p = 0; p < cur.n; p++) begin
      if (p == 0 || cur.brk[p-1]) begin
        check($sformatf("s%0d px%0d load tick", k, p),
              96'((pos < rec.size()) ? rec[pos] : 1'bx), 96'(1));
        pos++;
      end
      act = '0;
      for (int i = 0; i < 96; i++)
        act = {act[94:0], (pos + i < rec.size()) ? rec[pos + i] : 1'bx};
      check($sformatf("s%0d px%0d waveform", k, p), act, nrz_pattern(cur.exp[p]));
      pos += 96;
      if (cur.brk[p]) begin
        ones = 0;
        for (int i = 0; i < 200; i++)
          if (pos + i >= rec.size() || rec[pos + i] !== 1'b0) ones++;
        check($sformatf("s%0d px%0d latch low ticks not low", k, p), 96'(ones), 96'(0));
        check($sformatf("s%0d done%0d tick index", k, j),
              96'((j < done_idx.size()) ? done_idx[j] : -1), 96'(pos + 199));
        j++;
        pos += 200;
      end
    end
    ones = 0;
    for (int i = pos; i < rec.size(); i++) if (rec[i] !== 1'b0) ones++;
    check($sformatf("s%0d tail high ticks", k), 96'(ones), 96'(0));
    check($sformatf("s%0d done count", k), 96'(done_cnt), 96'(cur.exp_done));
    check($sformatf("s%0d underrun", k), 96'(underrun), 96'(cur.exp_underrun));
    check($sformatf("s%0d busy at end", k), 96'(busy), 96'(0));
    check($sformatf("s%0d stall seen", k), 96'(stall_seen != 0), 96'(cur.exp_stall));
    check($sformatf("s%0d first latency ok", k),
          96'((rise_cyc - xfer_cyc) >= 1 && (rise_cyc - xfer_cyc) <= 5), 96'(1));
  endtask

  initial begin
    int guard;

    tbl[0] = '{n: 1, data: {24'h0, 24'h0, 24'hA500FF}, last: 3'b001,
               delay: {8'd0, 8'd0, 8'd0}, brk: 3'b001,
`ifdef NRZ_GRB_ORDER_EN
               exp: {24'h0, 24'h0, 24'h00A5FF},
`else
               exp: {24'h0, 24'h0, 24'hA500FF},
`endif
               exp_done: 1, exp_underrun: 1'b0, exp_stall: 1'b0};
    tbl[1] = '{n: 3, data: {24'hF0F0F0, 24'h00FF00, 24'h123456}, last: 3'b100,
               delay: {8'd0, 8'd0, 8'd0}, brk: 3'b100,
`ifdef NRZ_GRB_ORDER_EN
               exp: {24'hF0F0F0, 24'hFF0000, 24'h341256},
`else
               exp: {24'hF0F0F0, 24'h00FF00, 24'h123456},
`endif
               exp_done: 1, exp_underrun: 1'b0, exp_stall: 1'b1};
    tbl[2] = '{n: 2, data: {24'h0, 24'h7FFFFE, 24'h800001}, last: 3'b010,
               delay: {8'd0, 8'd120, 8'd0}, brk: 3'b011,
`ifdef NRZ_GRB_ORDER_EN
               exp: {24'h0, 24'hFF7FFE, 24'h008001},
`else
               exp: {24'h0, 24'h7FFFFE, 24'h800001},
`endif
               exp_done: 2, exp_underrun: 1'b1, exp_stall: 1'b0};
    tbl[3] = '{n: 1, data: {24'h0, 24'h0, 24'h112233}, last: 3'b001,
               delay: {8'd0, 8'd0, 8'd0}, brk: 3'b001,
`ifdef NRZ_GRB_ORDER_EN
               exp: {24'h0, 24'h0, 24'h221133},
`else
               exp: {24'h0, 24'h0, 24'h112233},
`endif
               exp_done: 1, exp_underrun: 1'b0, exp_stall: 1'b0};

    reset = 1'b1; clken = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    div = 0; cyc = 0; rdy_q = 1'b0; cur.n = 0;
    clear_monitor();

    for (int k = 0; k < 4; k++) run_scenario(k, 1'b1);

    // Reset at bit 10 of a pixel: immediate abort, no latch gap, no done.
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_monitor();
    cur = tbl[3];
    guard = 0;
    while (rec.size() < 1 + 10 * 4 && guard < 4000) begin
      step();
      guard++;
    end
    check("abort reach bit 10 timeout", 96'(guard >= 4000), 96'(0));
    cur.n = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort {dout,done,underrun,busy,s_ready}",
          96'({dout, done, underrun, busy, s_ready}), 96'(5'b00001));
    capturing = 1'b0; hi_clks = 0; done_cnt = 0;
    repeat (1000) step();
    check("abort done pulses", 96'(done_cnt), 96'(0));
    check("abort dout high clks", 96'(hi_clks), 96'(0));

    // Next frame after the abort, with no further reset.
    run_scenario(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
